// File: rtl/deinterleaver.sv
// 48-bit BPSK block deinterleaver: ping-pong banks written in channel order,
// read out serially in pre-interleaver order with a one-cycle registered latency.
module deinterleaver (
    input  logic Clock,
    input  logic Reset,
    input  logic InputStart,
    input  logic InputValid,
    input  logic Input,
    output logic OutputValid,
    output logic Output,
    output logic Error
);

    typedef enum logic {StIdle, StRead} state_e;

    localparam logic [5:0] LastIdx = 6'd47;

    logic [1:0][47:0] mem_q, mem_d;
    logic [5:0]       wr_cnt_q, wr_cnt_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    state_e           state_q, state_d;
    logic [5:0]       k_q, k_d;
    logic             ov_q, ov_d;
    logic             out_q, out_d;
    logic             err_q, err_d;
    logic             handoff;

    // Output index k reads bank position 3*(k mod 16) + floor(k/16).
    function automatic logic [5:0] deint_addr(input logic [5:0] k);
        logic [5:0] m;
        m = {2'b00, k[3:0]};
        return m + (m << 1) + {4'b0000, k[5:4]};
    endfunction

    always_comb begin
        mem_d     = mem_q;
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        err_d     = 1'b0;
        handoff   = 1'b0;
        if (InputValid) begin
            if (InputStart && (wr_cnt_q != 6'd0)) begin
                // Resync: drop the partial block and restart at bit 0.
                mem_d[wr_bank_q][0] = Input;
                wr_cnt_d            = 6'd1;
                err_d               = 1'b1;
            end else begin
                mem_d[wr_bank_q][wr_cnt_q] = Input;
                if (wr_cnt_q == LastIdx) begin
                    wr_cnt_d  = 6'd0;
                    wr_bank_d = ~wr_bank_q;
                    handoff   = 1'b1;
                end else begin
                    wr_cnt_d = wr_cnt_q + 6'd1;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        rd_bank_d = rd_bank_q;
        ov_d      = 1'b0;
        out_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (handoff) begin
                    state_d   = StRead;
                    k_d       = 6'd0;
                    rd_bank_d = wr_bank_q;
                    ov_d      = 1'b1;
                    out_d     = mem_q[wr_bank_q][0];
                end
            end
            StRead: begin
                if (k_q != LastIdx) begin
                    k_d   = k_q + 6'd1;
                    ov_d  = 1'b1;
                    out_d = mem_q[rd_bank_q][deint_addr(k_q + 6'd1)];
                end else if (handoff) begin
                    // Back-to-back block: continue without passing through idle.
                    k_d       = 6'd0;
                    rd_bank_d = wr_bank_q;
                    ov_d      = 1'b1;
                    out_d     = mem_q[wr_bank_q][0];
                end else begin
                    state_d = StIdle;
                    k_d     = 6'd0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            wr_cnt_q  <= 6'd0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            state_q   <= StIdle;
            k_q       <= 6'd0;
            ov_q      <= 1'b0;
            out_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            state_q   <= state_d;
            k_q       <= k_d;
            ov_q      <= ov_d;
            out_q     <= out_d;
            err_q     <= err_d;
        end
    end

    // Bank contents carry no reset; stale data is never read before a full refill.
    always_ff @(posedge Clock) begin
        mem_q <= mem_d;
    end

    assign OutputValid = ov_q;
    assign Output      = out_q;
    assign Error       = err_q;

endmodule

// File: doc/deinterleaver.md
DEINTERLEAVER -- requirements
Module: deinterleaver

Interface
REQ-001 No parameters; block size is fixed at 48 coded bits (BPSK, N_CBPS=48, N_BPSC=1, one OFDM symbol).
REQ-002 Clock  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-low reset.
REQ-004 InputStart  input  1  marks the bit on Input as bit 0 of a new OFDM symbol; qualified by InputValid.
REQ-005 InputValid  input  1  Input carries a valid coded bit this cycle.
REQ-006 Input  input  1  serial coded bit, in channel (interleaved) order.
REQ-007 OutputValid  output  1  Output carries a valid deinterleaved bit this cycle.
REQ-008 Output  output  1  serial bit, in original (pre-interleaver) order.
REQ-009 Error  output  1  one-cycle pulse: partial block discarded.

Function
REQ-010 Write side SHALL store each accepted bit (InputValid=1) at address w = write counter (0..47) of the current write bank; counter increments per accepted bit.
REQ-011 Cycles with InputValid=0 SHALL change no write-side state; InputStart is ignored when InputValid=0.
REQ-012 Two 48-bit banks (ping-pong); on the edge accepting bit 47, the write bank SHALL toggle, the write counter SHALL wrap to 0, and the filled bank SHALL be handed to the read side.
REQ-013 Read side FSM states: IDLE, READ; IDLE->READ on bank handoff; READ->IDLE after output index k=47 unless a new handoff occurs on that same edge, in which case it stays in READ with k=0.
REQ-014 In READ, one bit per cycle for k=0..47, Output = bank[3*(k mod 16) + floor(k/16)], OutputValid=1; no stalls or gaps within a block.
REQ-015 Latency: OutputValid SHALL first be high in the cycle after the edge accepting bit 47 (1 cycle); Output and OutputValid are registered.
REQ-016 Input rate <= 1 bit/cycle guarantees a bank is fully read before it is refilled; back-to-back blocks SHALL produce contiguous OutputValid with no gap.
REQ-017 In IDLE, OutputValid=0 and Output=0.
REQ-018 InputStart=1 with InputValid=1 and write counter = 0: normal bit 0, no Error.
REQ-019 InputStart=1 with InputValid=1 and write counter != 0: partial block discarded (no handoff, no output), Error=1 for exactly the following cycle, current bit stored as bit 0, counter set to 1.
REQ-020 Write-side resync (REQ-019) SHALL NOT disturb a block currently in READ.

Reset
REQ-021 Reset low at a rising edge SHALL set: write counter=0, write bank=0, FSM=IDLE, k=0, OutputValid=0, Output=0, Error=0; bank contents need not be cleared.
REQ-022 Reset mid-block (write or read) SHALL abandon all in-progress blocks; OutputValid=0 from the next cycle; no output until a full new 48-bit block is accepted after Reset returns high.

Verification
REQ-023 Reset low 2 cycles, Input toggling -> OutputValid=0, Output=0, Error=0 throughout and 1 cycle after release.
REQ-024 48 continuous bits, only received bit 3 = 1 -> 48 OutputValid cycles starting 1 cycle after bit 47; only k=1 is 1. Received bit 1 = 1 -> only k=16 is 1; received bit 47 = 1 -> only k=47.
REQ-025 96 continuous bits (two blocks, distinct patterns) -> 96 contiguous OutputValid cycles, each block correctly deinterleaved, FSM never visits IDLE between blocks.
REQ-026 InputValid high every other cycle for 48 bits -> same output order as REQ-024; OutputValid high 48 consecutive cycles after bit 47.
REQ-027 InputStart with bit 20 of a block -> Error pulse 1 cycle; no output for the 20 discarded bits; next 48 bits (starting at the InputStart bit) produce one correct block.
REQ-028 Reset low during output k=10 -> OutputValid=0 next cycle, remaining 37 bits never output.
